// File: rtl/usb_pkg.sv
// usb_pkg: shared FX2LP FIFO addresses, packet defaults and flush-FSM state type
package usb_pkg;
    localparam logic [1:0] FIFOADR_EP2 = 2'b00;
    localparam logic [1:0] FIFOADR_EP6 = 2'b10;
    localparam int PKT_WORDS_DEF = 256;
    localparam int FLUSH_TIMEOUT_DEF = 1024;
    typedef enum logic [1:0] {IDLE, ARMED, FLUSH} flush_state_t;
endpackage

// File: rtl/usb_fifo_ram.sv
// usb_fifo_ram: simple dual-port word memory, synchronous write, asynchronous read
module usb_fifo_ram #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          CLKOUT,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge CLKOUT) if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: show-ahead word FIFO feeding the FX2LP EP6 write stage;
// the idle short-packet flush (pktend) is compiled in only with USB_TX_FIFO_FLUSH_EN.
module usb_tx_fifo
    import usb_pkg::*;
#(
    parameter int DEPTH_LOG2    = 9,
    parameter int PKT_WORDS     = PKT_WORDS_DEF,
    parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF,
    parameter int AF_MARGIN     = 4
) (
    input  logic                CLKOUT,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [15:0]         wr_data,
    output logic                full,
    output logic                almost_full,
    output logic                overflow,
    input  logic                rd_en,
    output logic [15:0]         rd_data,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                pktend
);
    localparam logic [DEPTH_LOG2:0] AF_THR = (DEPTH_LOG2+1)'(2**DEPTH_LOG2 - AF_MARGIN);
    logic [DEPTH_LOG2:0] wptr, rptr, wptr_n, rptr_n, count_n;
    logic push, pop;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign wptr_n  = wptr + {{DEPTH_LOG2{1'b0}}, push};
    assign rptr_n  = rptr + {{DEPTH_LOG2{1'b0}}, pop};
    assign count_n = wptr_n - rptr_n;
    usb_fifo_ram #(.AW(DEPTH_LOG2), .DW(16)) u_ram (
        .CLKOUT (CLKOUT),
        .we     (push),
        .waddr  (wptr[DEPTH_LOG2-1:0]),
        .wdata  (wr_data),
        .raddr  (rptr[DEPTH_LOG2-1:0]),
        .rdata  (rd_data)
    );
    // flags are registered from the next-state pointers so they track the pointers after each edge
    always_ff @(posedge CLKOUT or posedge rst)
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wptr        <= wptr_n;
            rptr        <= rptr_n;
            count       <= count_n;
            empty       <= wptr_n == rptr_n;
            full        <= wptr_n[DEPTH_LOG2-1:0] == rptr_n[DEPTH_LOG2-1:0] && wptr_n[DEPTH_LOG2] != rptr_n[DEPTH_LOG2];
            almost_full <= count_n >= AF_THR;
            overflow    <= overflow | (wr_en & full);
        end
`ifdef USB_TX_FIFO_FLUSH_EN
    localparam int PW = PKT_WORDS > 1 ? $clog2(PKT_WORDS) : 1;
    localparam int TW = FLUSH_TIMEOUT > 1 ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(FLUSH_TIMEOUT - 1);
    flush_state_t  state;
    logic [PW-1:0] pkt_cnt;
    logic [TW-1:0] timer;
    // a zero packet count never arms, so no zero-length packet is requested
    always_ff @(posedge CLKOUT or posedge rst)
        if (rst) begin
            state   <= IDLE;
            pkt_cnt <= '0;
            timer   <= '0;
            pktend  <= 1'b0;
        end else begin
            pkt_cnt <= state == FLUSH ? PW'(pop) : pkt_cnt + PW'(pop);
            pktend  <= 1'b0;
            case (state)
                IDLE:
                    if (pkt_cnt != '0 && empty) begin
                        state <= ARMED;
                        timer <= '0;
                    end
                ARMED:
                    if (pop || !empty) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == T_LAST) begin
                        state  <= FLUSH;
                        pktend <= 1'b1;
                    end else timer <= timer + 1'b1;
                default: state <= IDLE;
            endcase
        end
`else
    assign pktend = 1'b0;
`endif
endmodule

// File: tb/tb_usb_tx_fifo.sv
// tb_usb_tx_fifo: scoreboard bench for usb_tx_fifo; flush checks follow USB_TX_FIFO_FLUSH_EN
module tb_usb_tx_fifo;
`ifdef USB_TX_FIFO_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif
    logic        CLKOUT = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic        full, almost_full, overflow, empty, pktend;
    logic [15:0] rd_data;
    logic [9:0]  count;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] q[$];
    bit          m_ovf = 1'b0;
    bit          ar, aw;

    usb_tx_fifo dut (
        .CLKOUT      (CLKOUT),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .count       (count),
        .pktend      (pktend)
    );

    always #5 CLKOUT = ~CLKOUT;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_status(input bit pk_exp);
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == 512));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= 508));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("pktend", 32'(pktend), 32'(pk_exp));
    endtask

    task automatic step(input bit we, input logic [15:0] wd, input bit re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge CLKOUT);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
        #1;
        rst   = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        chk_status(1'b0);
        @(posedge CLKOUT);
        #1;
        rst = 1'b0;
    endtask

    // scoreboard: decides acceptance from the model, checks the head word on each accepted pop
    always @(negedge CLKOUT) if (!rst) begin
        ar = rd_en && q.size() > 0;
        aw = wr_en && q.size() < 512;
        if (wr_en && q.size() == 512) m_ovf = 1'b1;
        if (ar) begin
            chk("rd_data", 32'(rd_data), 32'(q[0]));
            q.delete(0);
        end
        if (aw) q.push_back(wr_data);
    end

    initial begin
        do_reset();
        step(1'b1, 16'h0100, 1'b0);
        step(1'b1, 16'h0200, 1'b0);
        step(1'b1, 16'h0300, 1'b0);
        chk_status(1'b0);
        chk("head_word", 32'(rd_data), 32'h0100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b1);
            chk_status(1'b0);
        end
        for (int i = 0; i < 512; i++) begin
            step(1'b1, 16'(16'h1000 + i), 1'b0);
            chk_status(1'b0);
        end
        step(1'b1, 16'hdead, 1'b0);
        chk_status(1'b0);
        step(1'b1, 16'hbeef, 1'b1);
        chk_status(1'b0);
        chk("count_after_full_pop", 32'(count), 32'd511);
        for (int i = 0; i < 511; i++) begin
            step(1'b0, 16'h0, 1'b1);
            chk_status(1'b0);
        end
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h2000 + i), 1'b0);
        for (int i = 0; i < 1200; i++) begin
            step(1'b1, 16'(i * 7 + 16'h4003), 1'b1);
            chk_status(1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
        chk_status(1'b0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'(16'h3000 + i), 1'b0);
            step(1'b0, 16'h0, 1'b1);
        end
        for (int k = 1; k <= 2200; k++) begin
            step(1'b0, 16'h0, 1'b0);
            chk("pktend_short", 32'(pktend), 32'(FLUSH_ON && k == 1025));
        end
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 16'(16'h5000 + i), 1'b0);
            step(1'b0, 16'h0, 1'b1);
        end
        for (int k = 0; k < 2000; k++) begin
            step(1'b0, 16'h0, 1'b0);
            chk("pktend_full_pkt", 32'(pktend), 32'h0);
        end
        do_reset();
        step(1'b1, 16'h6000, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        repeat (10) step(1'b0, 16'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h6100 + i), 1'b0);
        chk_status(1'b0);
        do_reset();
        for (int k = 0; k < 1200; k++) begin
            step(1'b0, 16'h0, 1'b0);
            chk("pktend_after_rst", 32'(pktend), 32'h0);
        end
        chk_status(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
